// File: rtl/timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for the MMIO timer slot.
// The TIMER_IRQ_EN build option is handled in mmio_timer_core; nothing here depends on it.
package timer_pkg;

    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_STATUS   = 5'd1;
    localparam logic [4:0] REG_PRESCALE = 5'd2;
    localparam logic [4:0] REG_COUNT_LO = 5'd3;
    localparam logic [4:0] REG_COUNT_HI = 5'd4;
    localparam logic [4:0] REG_CMP_LO   = 5'd5;
    localparam logic [4:0] REG_CMP_HI   = 5'd6;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_PERIODIC = 2;
    localparam int CTRL_IRQ_EN   = 3;

    localparam int STAT_MATCH   = 0;
    localparam int STAT_RUNNING = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the MMIO timer: pcnt runs 0..prescale while enabled and emits one tick per wrap.
// Clear or disable forces pcnt to 0 and suppresses the tick for that cycle.
module timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PRE_W-1:0] prescale,
    input  logic             enable,
    input  logic             clr,
    output logic             tick
);

    logic [PRE_W-1:0] pcnt_q;
    logic [PRE_W-1:0] pcnt_d;
    logic             at_end;

    always_comb begin
        at_end = (pcnt_q == prescale);
        tick   = enable && at_end && !clr;
        pcnt_d = pcnt_q + PRE_W'(1);
        if (!enable || clr || at_end) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer_core.sv
// MMIO timer slot: CNT_W-bit prescaled counter with compare match, one-shot/periodic modes
// and a COUNT_HI shadow latched on COUNT_LO reads. Define TIMER_IRQ_EN to add the irq output.
//
// state | meaning
// IDLE  | stopped, counter holds
// RUN   | counting on prescaler ticks
// DONE  | one-shot match reached, counter holds at CMP
module mmio_timer_core
    import timer_pkg::*;
#(
    parameter int CNT_W = 48,
    parameter int PRE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data
`ifdef TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int HI_W = CNT_W - 32;

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [HI_W-1:0]  shadow_q, shadow_d;
    logic             periodic_q, periodic_d;
    logic             match_q, match_d;
`ifdef TIMER_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
`endif

    logic wr_en, rd_en, ctrl_wr, clr, go_set, go_clr;
    logic tick, hit, running;

    assign wr_en   = cs && write;
    assign rd_en   = cs && read;
    assign ctrl_wr = wr_en && (addr == REG_CTRL);
    assign clr     = ctrl_wr && wr_data[CTRL_CLR];
    assign go_set  = ctrl_wr && wr_data[CTRL_GO];
    assign go_clr  = ctrl_wr && !wr_data[CTRL_GO];
    assign running = (state_q == RUN);
    assign hit     = tick && (count_q == cmp_q);

    timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .prescale (pre_q),
        .enable   (running),
        .clr      (clr),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        pre_d      = pre_q;
        shadow_d   = shadow_q;
        periodic_d = periodic_q;
        match_d    = match_q;

        case (state_q)
            IDLE:    if (go_set) state_d = RUN;
            RUN:     if (go_clr) state_d = IDLE;
                     else if (hit && !periodic_q) state_d = DONE;
            DONE:    if (go_set) state_d = RUN;
                     else if (clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Clear beats a tick; tick is already suppressed by the prescaler on clr.
        if (clr) begin
            count_d = '0;
        end else if (hit) begin
            if (periodic_q) count_d = '0;
        end else if (tick) begin
            count_d = count_q + CNT_W'(1);
        end

        if (wr_en && (addr == REG_STATUS) && wr_data[STAT_MATCH]) match_d = 1'b0;
        if (hit) match_d = 1'b1;

        // Snapshot the high word together with the low word the reader is given.
        if (rd_en && (addr == REG_COUNT_LO)) shadow_d = count_q[CNT_W-1:32];

        if (ctrl_wr) periodic_d = wr_data[CTRL_PERIODIC];
        if (wr_en && (addr == REG_PRESCALE)) pre_d = wr_data[PRE_W-1:0];
        if (wr_en && (addr == REG_CMP_LO)) cmp_d[31:0] = wr_data;
        if (wr_en && (addr == REG_CMP_HI)) cmp_d[CNT_W-1:32] = wr_data[HI_W-1:0];
    end

`ifdef TIMER_IRQ_EN
    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) irq_en_d = wr_data[CTRL_IRQ_EN];
        irq_d = match_q && irq_en_q;
    end

    assign irq = irq_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cmp_q      <= '1;
            pre_q      <= '0;
            shadow_q   <= '0;
            periodic_q <= 1'b0;
            match_q    <= 1'b0;
`ifdef TIMER_IRQ_EN
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            pre_q      <= pre_d;
            shadow_q   <= shadow_d;
            periodic_q <= periodic_d;
            match_q    <= match_d;
`ifdef TIMER_IRQ_EN
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        if (cs) begin
            case (addr)
                REG_CTRL: begin
                    rd_data[CTRL_GO]       = running;
                    rd_data[CTRL_PERIODIC] = periodic_q;
`ifdef TIMER_IRQ_EN
                    rd_data[CTRL_IRQ_EN]   = irq_en_q;
`endif
                end
                REG_STATUS: begin
                    rd_data[STAT_MATCH]   = match_q;
                    rd_data[STAT_RUNNING] = running;
                end
                REG_PRESCALE: rd_data[PRE_W-1:0] = pre_q;
                REG_COUNT_LO: rd_data = count_q[31:0];
                REG_COUNT_HI: rd_data[HI_W-1:0] = shadow_q;
                REG_CMP_LO:   rd_data = cmp_q[31:0];
                REG_CMP_HI:   rd_data[HI_W-1:0] = cmp_q[CNT_W-1:32];
                default:      rd_data = '0;
            endcase
        end
    end

endmodule
